// File: rtl/alu_seq_if.sv
// alu_seq_if: operation/result handshake bundle for alu_seq.
//   Request side : in_valid, in_ready, ALUopsel, MUXsel, operandA, operandB
//   Response side: out_valid, out_ready, ALUoutput, carry, overflow, equal,
//                  zero, negative, illegal
//   master modport = producer of operations and consumer of results
//   slave  modport = the ALU itself
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUopsel;
    logic             MUXsel;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUoutput;
    logic             carry;
    logic             overflow;
    logic             equal;
    logic             zero;
    logic             negative;
    logic             illegal;

    modport master (
        output in_valid, ALUopsel, MUXsel, operandA, operandB, out_ready,
        input  in_ready, out_valid, ALUoutput, carry, overflow, equal, zero,
               negative, illegal
    );

    modport slave (
        input  in_valid, ALUopsel, MUXsel, operandA, operandB, out_ready,
        output in_ready, out_valid, ALUoutput, carry, overflow, equal, zero,
               negative, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU with a persistent flag register.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : alu_seq_if.slave -- operation in (valid/ready), result + flags
//           out (valid/ready). Single-cycle arithmetic/logic ops; shifts run
//           one bit per cycle. The carry flag persists so ADC can chain words.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int SAW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000, OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_ADC = 4'b0011,
        OP_CMP = 4'b0100, OP_AND = 4'b0101, OP_OR  = 4'b0110, OP_NOT = 4'b0111,
        OP_XOR = 4'b1000, OP_SHL = 4'b1001, OP_SHR = 4'b1010, OP_MOV = 4'b1011
    } op_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, eq_q, eq_d;
    logic             zero_q, zero_d, neg_q, neg_d, ill_q, ill_d;
    // Shifter working state, loaded at accept and consumed in SHIFT.
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [SAW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d, amsb_q, amsb_d, eqp_q, eqp_d;

    op_e              op;
    logic [WIDTH-1:0] a, b, addb;
    logic [SAW-1:0]   k;
    logic             cin, add_ovf, in_ready_w, accept;
    logic [WIDTH:0]   sum;

    // Combinational decode/shift temporaries.
    logic [WIDTH-1:0] sh_next, res_v, fsrc;
    logic             sh_out, c_v, o_v, ill_v, wr;

    assign op  = op_e'(bus.ALUopsel);
    assign a   = bus.operandA;
    assign b   = bus.operandB;
    assign k   = bus.operandB[SAW-1:0];

    // DONE can take a new op in the same cycle its result departs.
    assign in_ready_w = rst_n && ((state_q == IDLE) ||
                                  (state_q == DONE && bus.out_ready));
    assign accept     = bus.in_valid && in_ready_w;

    // Shared adder: SUB/CMP use A + ~B + 1, ADC injects the registered carry.
    always_comb begin
        addb = b;
        cin  = 1'b0;
        case (op)
            OP_SUB, OP_CMP: begin
                addb = ~b;
                cin  = 1'b1;
            end
            OP_ADC:  cin = carry_q;
            default: ;
        endcase
    end

    assign sum     = {1'b0, a} + {1'b0, addb} + {{WIDTH{1'b0}}, cin};
    assign add_ovf = (a[MSB] == addb[MSB]) && (sum[MSB] != a[MSB]);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        eq_d     = eq_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ill_d    = ill_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        amsb_d   = amsb_q;
        eqp_d    = eqp_q;
        sh_next  = '0;
        sh_out   = 1'b0;
        res_v    = '0;
        fsrc     = '0;
        c_v      = carry_q;
        o_v      = ovf_q;
        ill_v    = 1'b0;
        wr       = 1'b0;

        case (state_q)
            IDLE: ;
            SHIFT: begin
                if (left_q) begin
                    sh_next = {sh_q[MSB-1:0], 1'b0};
                    sh_out  = sh_q[MSB];
                end else begin
                    sh_next = {1'b0, sh_q[MSB:1]};
                    sh_out  = sh_q[0];
                end
                sh_d  = sh_next;
                cnt_d = cnt_q - SAW'(1);
                if (cnt_q == SAW'(1)) begin
                    result_d = sh_next;
                    carry_d  = sh_out;
                    ovf_d    = left_q && (sh_next[MSB] ^ amsb_q);
                    eq_d     = eqp_q;
                    zero_d   = (sh_next == '0);
                    neg_d    = sh_next[MSB];
                    ill_d    = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = DONE;
            wr      = 1'b1;
            case (op)
                OP_NOP: ;
                OP_ADD, OP_SUB, OP_ADC: begin
                    res_v = sum[MSB:0];
                    fsrc  = sum[MSB:0];
                    c_v   = sum[WIDTH];
                    o_v   = add_ovf;
                end
                OP_CMP: begin
                    res_v = result_q;
                    fsrc  = sum[MSB:0];
                    c_v   = sum[WIDTH];
                    o_v   = add_ovf;
                end
                OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                    case (op)
                        OP_AND:  res_v = a & b;
                        OP_OR:   res_v = a | b;
                        OP_XOR:  res_v = a ^ b;
                        default: res_v = ~a;
                    endcase
                    fsrc = res_v;
                    c_v  = 1'b0;
                    o_v  = 1'b0;
                end
                OP_SHL, OP_SHR: begin
                    if (k == '0) begin
                        res_v = a;
                        fsrc  = a;
                        c_v   = 1'b0;
                        o_v   = 1'b0;
                    end else begin
                        // Flags stay untouched until the last shift step.
                        wr      = 1'b0;
                        state_d = SHIFT;
                        sh_d    = a;
                        cnt_d   = k;
                        left_d  = (op == OP_SHL);
                        amsb_d  = a[MSB];
                        eqp_d   = (a == b);
                    end
                end
                OP_MOV: begin
                    res_v = bus.MUXsel ? b : a;
                    fsrc  = res_v;
                end
                default: begin
                    ill_v = 1'b1;
                    c_v   = 1'b0;
                    o_v   = 1'b0;
                end
            endcase
            if (wr) begin
                result_d = res_v;
                carry_d  = c_v;
                ovf_d    = o_v;
                ill_d    = ill_v;
                eq_d     = !ill_v && (a == b);
                zero_d   = !ill_v && (fsrc == '0);
                neg_d    = !ill_v && fsrc[MSB];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            eq_q     <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ill_q    <= 1'b0;
            sh_q     <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            amsb_q   <= 1'b0;
            eqp_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            eq_q     <= eq_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ill_q    <= ill_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            amsb_q   <= amsb_d;
            eqp_q    <= eqp_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state_q == DONE);
    assign bus.ALUoutput = result_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.equal     = eq_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = neg_q;
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq (WIDTH = 32).
// Flags are compared as the packed vector {carry, overflow, equal, zero, negative}.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [3:0]  s_op [0:8];
    logic [31:0] s_a  [0:8];
    logic [31:0] s_b  [0:8];
    logic [31:0] s_r  [0:8];
    logic        s_c  [0:8];

    function automatic logic [4:0] flg();
        return {bus.carry, bus.overflow, bus.equal, bus.zero, bus.negative};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic mux,
                         input logic [31:0] a, input logic [31:0] b);
        bus.ALUopsel = op;
        bus.MUXsel   = mux;
        bus.operandA = a;
        bus.operandB = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s_op = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'hB, 4'h1, 4'h1, 4'h1};
        s_a  = '{32'h1, 32'h10, 32'hFFFF, 32'h12345678, 32'h80000000,
                 32'hDEAD, 32'd100, 32'hAAAAAAAA, 32'h7FFF0000};
        s_b  = '{32'h2, 32'h20, 32'h1, 32'h11111111, 32'h80000000,
                 32'hBEEF, 32'd200, 32'h55555555, 32'h0000FFFF};
        s_r  = '{32'h3, 32'h30, 32'h10000, 32'h23456789, 32'h0,
                 32'hBEEF, 32'h12C, 32'hFFFFFFFF, 32'h7FFFFFFF};
        s_c  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.ALUopsel = '0;
        bus.MUXsel   = 1'b0;
        bus.operandA = '0;
        bus.operandB = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_result", bus.ALUoutput, 32'h0);
        check("rst_flags", 32'({bus.illegal, flg()}), 32'h0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(bus.in_ready), 32'h1);

        // ADD with signed overflow, result one cycle after accept
        issue(4'h1, 1'b0, 32'h7FFFFFFF, 32'h1);
        check("add_ovf_valid", 32'(bus.out_valid), 32'h1);
        check("add_ovf_result", bus.ALUoutput, 32'h80000000);
        check("add_ovf_flags", 32'(flg()), 32'(5'b01001));
        tick();
        check("add_ovf_taken", 32'(bus.out_valid), 32'h0);

        // Multi-word: ADD sets carry, ADC (accepted from DONE) consumes it
        issue(4'h1, 1'b0, 32'hFFFFFFFF, 32'h1);
        check("add_c_result", bus.ALUoutput, 32'h0);
        check("add_c_flags", 32'(flg()), 32'(5'b10010));
        issue(4'h3, 1'b0, 32'h0, 32'h0);
        check("adc_result", bus.ALUoutput, 32'h1);
        check("adc_flags", 32'(flg()), 32'(5'b00100));

        // SHL by 4: out_valid exactly 4 edges after accept
        issue(4'h9, 1'b0, 32'h80000001, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("shl_busy_valid", 32'(bus.out_valid), 32'h0);
            check("shl_busy_ready", 32'(bus.in_ready), 32'h0);
            tick();
        end
        check("shl_valid", 32'(bus.out_valid), 32'h1);
        check("shl_result", bus.ALUoutput, 32'h10);
        check("shl_flags", 32'(flg()), 32'(5'b01000));

        // SHR by 1
        issue(4'hA, 1'b0, 32'h3, 32'h1);
        check("shr_busy_valid", 32'(bus.out_valid), 32'h0);
        tick();
        check("shr_valid", 32'(bus.out_valid), 32'h1);
        check("shr_result", bus.ALUoutput, 32'h1);
        check("shr_flags", 32'(flg()), 32'(5'b10000));
        tick();

        // Backpressure after CMP; pending XOR must not be taken early
        bus.out_ready = 1'b0;
        issue(4'h4, 1'b0, 32'h5, 32'h5);
        check("cmp_valid", 32'(bus.out_valid), 32'h1);
        check("cmp_result", bus.ALUoutput, 32'h1);
        check("cmp_flags", 32'(flg()), 32'(5'b10110));
        bus.ALUopsel = 4'h8;
        bus.operandA = 32'hF0;
        bus.operandB = 32'hFF;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_in_ready", 32'(bus.in_ready), 32'h0);
            check("bp_out_valid", 32'(bus.out_valid), 32'h1);
            check("bp_result", bus.ALUoutput, 32'h1);
            check("bp_flags", 32'(flg()), 32'(5'b10110));
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_valid = 1'b0;
        check("xor_valid", 32'(bus.out_valid), 32'h1);
        check("xor_result", bus.ALUoutput, 32'h0F);
        check("xor_flags", 32'(flg()), 32'(5'b00000));

        // Reset in the 3rd cycle of a long shift
        issue(4'h9, 1'b0, 32'h1, 32'd31);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        check("rst_mid_valid", 32'(bus.out_valid), 32'h0);
        check("rst_mid_result", bus.ALUoutput, 32'h0);
        check("rst_mid_flags", 32'({bus.illegal, flg()}), 32'h0);
        rst_n = 1'b1;
        #1;
        check("rst_mid_rel_ready", 32'(bus.in_ready), 32'h1);
        tick();
        check("rst_mid_no_resume", 32'(bus.out_valid), 32'h0);

        // Illegal opcode clears carry set by the previous op
        issue(4'h1, 1'b0, 32'hFFFFFFFF, 32'h1);
        check("pre_ill_flags", 32'(flg()), 32'(5'b10010));
        issue(4'hF, 1'b0, 32'h5, 32'h5);
        check("ill_result", bus.ALUoutput, 32'h0);
        check("ill_flags", 32'({bus.illegal, flg()}), 32'(6'b100000));
        tick();
        check("ill_taken", 32'(bus.out_valid), 32'h0);

        // Back-to-back stream with an interleaved MOV (carry preserved)
        bus.in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.ALUopsel = s_op[i];
            bus.MUXsel   = 1'b1;
            bus.operandA = s_a[i];
            bus.operandB = s_b[i];
            tick();
            check("stream_valid", 32'(bus.out_valid), 32'h1);
            check("stream_result", bus.ALUoutput, s_r[i]);
            check("stream_carry", 32'(bus.carry), 32'(s_c[i]));
        end
        bus.in_valid = 1'b0;
        tick();
        check("stream_drain", 32'(bus.out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked, registered ALU that replaces the combinational datapath ALU in the execute stage. It accepts one operation per valid/ready transfer, executes single-cycle arithmetic/logic ops and multi-cycle barrel-free shifts (one bit per cycle), and holds result plus a persistent flag register until the consumer takes it. The persistent carry flag enables multi-word arithmetic through an ADC opcode.

## Interface
- WIDTH, 32, datapath width; power of two, at least 8.
- SAW, $clog2(WIDTH), shift-amount width (derived; not overridden).

- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operation present.
- in_ready  output  1  block can accept an operation this cycle.
- ALUopsel  input  4  opcode (below).
- MUXsel  input  1  MOV source select: 1 = operandB, 0 = operandA.
- operandA  input  WIDTH  first operand.
- operandB  input  WIDTH  second operand; its low SAW bits are the shift amount for shifts.
- out_valid  output  1  ALUoutput/flags hold a completed result.
- out_ready  input  1  consumer takes the result.
- ALUoutput  output  WIDTH  registered result.
- carry, overflow, equal, zero, negative  output  1 each  registered flags.
- illegal  output  1  the last completed op had an undefined opcode.

## Operation
- Opcodes:
  - 0000 NOP: result = 0.
  - 0001 ADD: A+B.
  - 0010 SUB: A+~B+1.
  - 0011 ADC: A+B+carry_flag.
  - 0100 CMP: A−B; the flags update, ALUoutput is unchanged.
  - 0101 AND, 0110 OR, 1000 XOR: bitwise.
  - 0111 NOT: ~A, bitwise.
  - 1001 SHL: A shifted left by k = B[SAW-1:0].
  - 1010 SHR: A shifted right logically by k.
  - 1011 MOV: MUXsel ? B : A.
  - All other opcodes are illegal: result = 0, illegal = 1, all other flags 0.
- Flag rules:
  - ADD/SUB/ADC/CMP: carry = bit WIDTH of the (WIDTH+1)-bit sum. For SUB/CMP, carry = 1 means no borrow. overflow = signed overflow, i.e. both addends share a sign and the sum's sign differs (addends are A and ~B for SUB/CMP).
  - SHL: carry = last bit shifted out; overflow = result[MSB] ^ A[MSB].
  - SHR: carry = last bit shifted out; overflow = 0.
  - A shift with k = 0 gives result = A, carry = 0, overflow = 0.
  - AND/OR/XOR/NOT: carry = 0, overflow = 0.
  - NOP/MOV: carry and overflow are preserved.
  - All ops: equal = (A == B), zero = (result == 0), negative = result[MSB]. CMP uses its difference for zero and negative.
- The carry flag persists between ops; ADC reads the registered value.
- FSM states:
  - IDLE: in_ready = 1. On accept, a non-shift op or a shift with k = 0 goes to DONE. A shift with k > 0 loads the shifter and goes to SHIFT.
  - SHIFT: shifts one bit per cycle and decrements the counter. On the final bit it writes the result and flags and goes to DONE. in_ready = 0.
  - DONE: out_valid = 1, and outputs are stable. With out_ready = 1, the block goes to IDLE, or accepts a new op in the same cycle (in_ready = out_ready in DONE).
- Reset (rst_n low at a clock edge), including mid-SHIFT or DONE: state → IDLE. ALUoutput and all flags → 0, illegal → 0, out_valid → 0. In-flight work is discarded. in_ready = 0 while rst_n is low, and 1 in the first cycle after release.

## Timing
- Handshake:
  - Transfer on an input edge where in_valid & in_ready; transfer on an output edge where out_valid & out_ready.
  - Inputs are sampled only at the accept edge; later input changes have no effect.
- Latency, accept at edge N:
  - Non-shift op or k = 0: out_valid is high after edge N.
  - Shift with k ≥ 1: out_valid is high after edge N+k.
- Throughput: one op per cycle when out_ready stays high and ops are non-shift (DONE accepts back-to-back).
- Backpressure: while out_valid & !out_ready, ALUoutput, the flags and illegal hold, and in_ready = 0.
- Simultaneous output transfer and new input accept in DONE: the new result appears after the same edge, and ADC uses the carry flag of the departing result.
- Maximum shift: k = WIDTH−1 takes WIDTH−1 SHIFT cycles; out_valid follows after edge N+WIDTH−1.

## Test plan
- Reset then ADD, WIDTH=32, A=0x7FFFFFFF, B=1, out_ready=1:
  - ALUoutput=0x80000000, overflow=1, carry=0, negative=1, out_valid one cycle after accept.
- Multi-word add:
  - ADD A=0xFFFFFFFF, B=1 → 0, carry=1, zero=1.
  - Then ADC A=0, B=0 → 1, carry=0.
- Shifts:
  - SHL A=0x80000001, B=4 → 0x00000010, carry=0, overflow=1, out_valid exactly 4 cycles after accept.
  - SHR A=0x3, B=1 → 0x1, carry=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after CMP A=5, B=5. ALUoutput is unchanged, equal=1, zero=1, carry=1, in_ready=0 throughout.
  - Raising out_ready together with in_valid (XOR A=0xF0, B=0xFF) gives 0x0F on the next cycle.
- Reset and illegal opcode:
  - Assert rst_n=0 in the 3rd cycle of SHL B=31. All outputs are 0 and in_ready=1 one cycle after release.
  - Then opcode 1111 → ALUoutput=0, illegal=1, carry/overflow=0.
- Back-to-back stream: 8 ADD ops with out_ready=1 complete in 8 consecutive cycles with correct sums; the MOV with MUXsel=1 interleaved in the stream returns B.
